gauss_smooth_stream: RTL and testbench
======================================

Name: gauss_smooth_stream

Overview:
- Parametrised successor of the fixed 5-tap column smoother in the feature front-end.
- Accepts one vertical pixel column per handshake. Applies a separable binomial Gaussian of size KSIZE (3 or 5): vertical weighted sum, then a horizontal window over column sums.
- Replicates edge columns at line start and end and emits exactly WIDTH smoothed pixels per line.
- Adds valid/ready handshake, rounding, end-of-line marker and bypass mode.

Parameters:
- PIX_W, 8, pixel bit width.
- KSIZE, 5, kernel size. Only 3 or 5 legal; any other value is an elaboration error.
- WIDTH, 640, pixels per line. Must be > KSIZE.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_valid  in  1  column valid
- o_ready  out  1  block can accept a column
- i_col  in  KSIZE*PIX_W  column, top row in MSBs
- i_bypass  in  1  1 = output unfiltered centre pixel
- o_valid  out  1  output pixel valid
- o_pixel  out  PIX_W  smoothed (or bypassed) pixel
- o_eol  out  1  high with o_valid for pixel x = WIDTH-1

Behaviour:
- Weights:
  - KSIZE=3: 1 2 1.
  - KSIZE=5: 1 4 6 4 1.
  - Applied vertically and horizontally; total weight 2^(2*(KSIZE-1)).
- Column sum width: PIX_W+KSIZE-1 bits. Horizontal sum width: PIX_W+2*(KSIZE-1) bits. No truncation before final rounding.
- Output value: (hsum + 2^(2*KSIZE-3)) >> (2*(KSIZE-1)), i.e. round-half-up. Result never exceeds 2^PIX_W-1.
- Accept: a column is accepted on a clock edge where i_valid && o_ready. R = (KSIZE-1)/2.
- Window:
  - KSIZE-entry shift register of column sums, plus a parallel shift register of each column's centre-row pixel (row R).
  - Column counter c is 0..WIDTH-1.
- State machine:
  - FIRST (reset state), o_ready=1. On accept of column 0: load every window entry with that column's sum and centre pixel; c<=1; go to RUN. No output.
  - RUN, o_ready=1. On accept: shift in new column, c<=c+1. If accepted c >= R, the window holds the clamped columns c-2R..c with centre x=c-R, and an output is scheduled. Accepting c=WIDTH-1 goes to FLUSH with flush counter = R.
  - FLUSH, o_ready=0, i_valid ignored. Each cycle, shift in a duplicate of the last column's sum/pixel and schedule output for centre x = WIDTH-R..WIDTH-1. After R cycles go to FIRST, c<=0.
- Output timing:
  - A scheduled window is summed combinationally and registered.
  - o_valid/o_pixel/o_eol are asserted for exactly one cycle, at the edge after the window-update edge (1-cycle latency from window update).
  - Outputs leave in strictly increasing x order, exactly WIDTH per line.
  - There is no output backpressure.
- Bypass: o_pixel = window centre pixel, with identical timing/valid. i_bypass is sampled at the output register edge; changing it mid-line is legal and applies per pixel.
- Gaps: i_valid low in FIRST/RUN holds all state; no output.
- Back-to-back lines: FIRST accepts in the cycle after FLUSH ends (one-cycle o_ready=1 before new line is allowed, no bubble required beyond the R flush cycles).
- Reset (any time, including mid-line or mid-flush):
  - Registers: state=FIRST, c=0, windows=0.
  - Outputs: o_valid=0, o_pixel=0, o_eol=0, o_ready=1 after reset deasserts.
  - No partial-line output is produced afterwards.

Test Plan:
- Flat field, KSIZE=5, WIDTH=16, all pixels 100, i_valid continuous -> 16 outputs all 100; o_eol only on the 16th; o_ready low exactly 2 cycles after the last column.
- Impulse, KSIZE=5, WIDTH=16, all zero except centre row col 8 = 255 -> x=6,7,8,9,10 = 6,24,36,24,6; all others 0.
- Ramp with borders, KSIZE=3, WIDTH=8, column x all rows = 10*x -> x=0:3, x=3:30, x=7:68.
- Rounding and bypass, KSIZE=3:
  - Single pixel 2 at centre row, others 0 -> that x outputs 1 (8/16 rounds up).
  - Same stimulus with i_bypass=1 -> output 2 at that x; other pixels 0.
- Random i_valid gaps (30% idle) over 3 back-to-back lines -> outputs identical to the gap-free reference model; no accept during FLUSH.
- Assert i_rst_n low at column 9 of line 1, then send a full clean line -> no o_valid between reset and new line; the new line matches the model exactly; max input 255 everywhere gives 255.

Source files
------------

// File: rtl/gauss_smooth_stream.sv
// Separable binomial smoother (3x3 or 5x5) over a column stream with edge-column replication.
// Latency: one cycle from a window update to o_valid; R flush cycles after the last column of a line.
// Backpressure: o_ready drops only while flushing the right border; the output has no backpressure.
module gauss_smooth_stream #(
    parameter int PIX_W = 8,
    parameter int KSIZE = 5,
    parameter int WIDTH = 640
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic [KSIZE*PIX_W-1:0] i_col,
    input  logic                   i_bypass,
    output logic                   o_valid,
    output logic [PIX_W-1:0]       o_pixel,
    output logic                   o_eol
);

    localparam int R   = (KSIZE - 1) / 2;
    localparam int CSW = PIX_W + KSIZE - 1;
    localparam int HSW = PIX_W + 2 * (KSIZE - 1);
    localparam int SH  = 2 * (KSIZE - 1);
    localparam int CW  = $clog2(WIDTH);
    localparam int FW  = $clog2(R + 1);
    localparam logic [HSW-1:0] HALF = HSW'(1) << (2 * KSIZE - 3);

    if (KSIZE != 3 && KSIZE != 5) begin : g_bad_ksize
        $error("gauss_smooth_stream: KSIZE must be 3 or 5");
    end
    if (WIDTH <= KSIZE) begin : g_bad_width
        $error("gauss_smooth_stream: WIDTH must exceed KSIZE");
    end

    // Binomial tap weight; the kernel is symmetric so row and column order do not matter.
    function automatic int unsigned weight(input int idx);
        if (KSIZE == 3) begin
            return (idx == 1) ? 2 : 1;
        end
        case (idx)
            0, 4:    return 1;
            1, 3:    return 4;
            default: return 6;
        endcase
    endfunction

    typedef enum logic [1:0] {S_FIRST, S_RUN, S_FLUSH} state_t;

    state_t           state;
    logic [CW-1:0]    c;
    logic [FW-1:0]    fcnt;
    logic [CSW-1:0]   win_sum [KSIZE];
    logic [PIX_W-1:0] win_pix [KSIZE];
    logic             sched_vld;
    logic             sched_eol;

    logic             accept;
    logic [PIX_W-1:0] in_pix;
    logic [CSW-1:0]   in_sum;
    logic [CSW-1:0]   nxt_sum;
    logic [PIX_W-1:0] nxt_pix;
    logic [HSW-1:0]   hsum;

    assign o_ready = (state != S_FLUSH);
    assign accept  = i_valid && o_ready;
    assign in_pix  = i_col[(KSIZE-1-R)*PIX_W +: PIX_W];

    // Vertical weighted sum of the incoming column (row 0 sits in the MSBs).
    always_comb begin
        in_sum = '0;
        for (int r = 0; r < KSIZE; r++) begin
            in_sum = in_sum + CSW'(weight(r)) * CSW'(i_col[(KSIZE-1-r)*PIX_W +: PIX_W]);
        end
    end

    // While flushing, the newest column is replicated to clamp the right border.
    always_comb begin
        nxt_sum = (state == S_FLUSH) ? win_sum[KSIZE-1] : in_sum;
        nxt_pix = (state == S_FLUSH) ? win_pix[KSIZE-1] : in_pix;
    end

    // Horizontal weighted sum across the window of column sums, at full precision.
    always_comb begin
        hsum = '0;
        for (int i = 0; i < KSIZE; i++) begin
            hsum = hsum + HSW'(weight(i)) * HSW'(win_sum[i]);
        end
    end

    // Line FSM: left-border preload, steady streaming, right-border flush.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= S_FIRST;
            c         <= '0;
            fcnt      <= '0;
            sched_vld <= 1'b0;
            sched_eol <= 1'b0;
            for (int i = 0; i < KSIZE; i++) begin
                win_sum[i] <= '0;
                win_pix[i] <= '0;
            end
        end else begin
            sched_vld <= 1'b0;
            sched_eol <= 1'b0;
            if ((state == S_RUN && accept) || state == S_FLUSH) begin
                for (int i = 0; i < KSIZE - 1; i++) begin
                    win_sum[i] <= win_sum[i+1];
                    win_pix[i] <= win_pix[i+1];
                end
                win_sum[KSIZE-1] <= nxt_sum;
                win_pix[KSIZE-1] <= nxt_pix;
            end
            case (state)
                S_FIRST: begin
                    if (accept) begin
                        for (int i = 0; i < KSIZE; i++) begin
                            win_sum[i] <= in_sum;
                            win_pix[i] <= in_pix;
                        end
                        c     <= CW'(1);
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (accept) begin
                        if (c >= CW'(R)) begin
                            sched_vld <= 1'b1;
                        end
                        if (c == CW'(WIDTH - 1)) begin
                            state <= S_FLUSH;
                            fcnt  <= FW'(R);
                        end else begin
                            c <= c + CW'(1);
                        end
                    end
                end
                S_FLUSH: begin
                    sched_vld <= 1'b1;
                    sched_eol <= (fcnt == FW'(1));
                    fcnt      <= fcnt - FW'(1);
                    if (fcnt == FW'(1)) begin
                        state <= S_FIRST;
                        c     <= '0;
                    end
                end
                default: state <= S_FIRST;
            endcase
        end
    end

    // Output register: round-half-up normalisation or centre-pixel bypass.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid <= 1'b0;
            o_pixel <= '0;
            o_eol   <= 1'b0;
        end else begin
            o_valid <= sched_vld;
            o_eol   <= sched_vld && sched_eol;
            if (sched_vld) begin
                o_pixel <= i_bypass ? win_pix[R] : PIX_W'((hsum + HALF) >> SH);
            end
        end
    end

endmodule

// File: tb/tb_gauss_smooth_stream.sv
// Bench for gauss_smooth_stream: a 5x5/16-wide and a 3x3/8-wide instance with queue scoreboards.
// Expected pixels come from a direct 2-D convolution over clamped coordinates.
// Monitors pop one expectation per o_valid; stimulus drivers honour o_ready.
module tb_gauss_smooth_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        v5, b5;
    logic [39:0] col5;
    logic        r5, ov5, oe5;
    logic [7:0]  op5;

    logic        v3, b3;
    logic [23:0] col3;
    logic        r3, ov3, oe3;
    logic [7:0]  op3;

    gauss_smooth_stream #(.PIX_W(8), .KSIZE(5), .WIDTH(16)) dut5 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(v5), .o_ready(r5), .i_col(col5),
        .i_bypass(b5), .o_valid(ov5), .o_pixel(op5), .o_eol(oe5)
    );

    gauss_smooth_stream #(.PIX_W(8), .KSIZE(3), .WIDTH(8)) dut3 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(v3), .o_ready(r3), .i_col(col3),
        .i_bypass(b3), .o_valid(ov3), .o_pixel(op3), .o_eol(oe3)
    );

    typedef struct {
        int pix;
        bit eol;
    } exp_t;

    exp_t q5[$];
    exp_t q3[$];
    int   pix5[16][5];
    int   pix3[8][3];
    int   w5[5] = '{1, 4, 6, 4, 1};
    int   w3[3] = '{1, 2, 1};
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int clampi(input int x, input int w);
        return (x < 0) ? 0 : ((x > w - 1) ? w - 1 : x);
    endfunction

    // Reference: full 2-D binomial convolution with replicated borders, then round half up.
    function automatic int model5(input int x, input bit byp);
        int acc = 0;
        if (byp) return pix5[x][2];
        for (int dx = -2; dx <= 2; dx++)
            for (int dy = 0; dy < 5; dy++)
                acc += w5[dx+2] * w5[dy] * pix5[clampi(x + dx, 16)][dy];
        return (acc + 128) / 256;
    endfunction

    function automatic int model3(input int x, input bit byp);
        int acc = 0;
        if (byp) return pix3[x][1];
        for (int dx = -1; dx <= 1; dx++)
            for (int dy = 0; dy < 3; dy++)
                acc += w3[dx+1] * w3[dy] * pix3[clampi(x + dx, 8)][dy];
        return (acc + 8) / 16;
    endfunction

    task automatic push5(input bit byp, input int nx);
        exp_t e;
        for (int x = 0; x < nx; x++) begin
            e.pix = model5(x, byp);
            e.eol = (x == 15);
            q5.push_back(e);
        end
    endtask

    task automatic push3(input bit byp);
        exp_t e;
        for (int x = 0; x < 8; x++) begin
            e.pix = model3(x, byp);
            e.eol = (x == 7);
            q3.push_back(e);
        end
    endtask

    function automatic logic [39:0] pack5(input int x);
        logic [39:0] p;
        for (int r = 0; r < 5; r++) p[(4-r)*8 +: 8] = 8'(pix5[x][r]);
        return p;
    endfunction

    function automatic logic [23:0] pack3(input int x);
        logic [23:0] p;
        for (int r = 0; r < 3; r++) p[(2-r)*8 +: 8] = 8'(pix3[x][r]);
        return p;
    endfunction

    task automatic send5(input logic [39:0] c);
        int n = 0;
        @(negedge clk);
        v5 = 1'b1;
        col5 = c;
        while (!r5 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("k5_ready_timeout", 0, 1);
        @(posedge clk);
    endtask

    task automatic send3(input logic [23:0] c);
        int n = 0;
        @(negedge clk);
        v3 = 1'b1;
        col3 = c;
        while (!r3 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("k3_ready_timeout", 0, 1);
        @(posedge clk);
    endtask

    task automatic idle5();
        @(negedge clk);
        v5 = 1'b0;
    endtask

    task automatic idle3();
        @(negedge clk);
        v3 = 1'b0;
    endtask

    task automatic send_line5(input bit gaps, input int ncols);
        for (int x = 0; x < ncols; x++) begin
            if (gaps) begin
                for (int k = 0; k < 4 && $urandom_range(0, 99) < 30; k++) idle5();
            end
            send5(pack5(x));
        end
    endtask

    task automatic send_line3(input bit gaps);
        for (int x = 0; x < 8; x++) begin
            if (gaps) begin
                for (int k = 0; k < 4 && $urandom_range(0, 99) < 30; k++) idle3();
            end
            send3(pack3(x));
        end
    endtask

    task automatic drain5();
        int n = 0;
        while (q5.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check("k5_drain_left", q5.size(), 0);
    endtask

    task automatic drain3();
        int n = 0;
        while (q3.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check("k3_drain_left", q3.size(), 0);
    endtask

    always @(negedge clk) begin : mon5
        exp_t e;
        if (ov5) begin
            if (q5.size() == 0) begin
                check("k5_unexpected_valid", 1, 0);
            end else begin
                e = q5.pop_front();
                check("k5_pixel", int'(op5), e.pix);
                check("k5_eol", int'(oe5), int'(e.eol));
            end
        end
    end

    always @(negedge clk) begin : mon3
        exp_t e;
        if (ov3) begin
            if (q3.size() == 0) begin
                check("k3_unexpected_valid", 1, 0);
            end else begin
                e = q3.pop_front();
                check("k3_pixel", int'(op3), e.pix);
                check("k3_eol", int'(oe3), int'(e.eol));
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        rst_n = 1'b0;
        v5 = 1'b0; b5 = 1'b0; col5 = '0;
        v3 = 1'b0; b3 = 1'b0; col3 = '0;
        repeat (3) @(negedge clk);
        check("rst_k5_valid", int'(ov5), 0);
        check("rst_k5_pixel", int'(op5), 0);
        check("rst_k5_eol", int'(oe5), 0);
        check("rst_k3_valid", int'(ov3), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_k5_ready", int'(r5), 1);
        check("rst_k3_ready", int'(r3), 1);

        // Flat field: everything stays at 100, ready drops for exactly the flush.
        for (int x = 0; x < 16; x++) for (int r = 0; r < 5; r++) pix5[x][r] = 100;
        push5(1'b0, 16);
        send_line5(1'b0, 16);
        @(negedge clk);
        v5 = 1'b0;
        check("flat_ready_flush1", int'(r5), 0);
        @(negedge clk);
        check("flat_ready_flush2", int'(r5), 0);
        @(negedge clk);
        check("flat_ready_after", int'(r5), 1);
        drain5();

        // Impulse on the centre row.
        for (int x = 0; x < 16; x++) for (int r = 0; r < 5; r++) pix5[x][r] = 0;
        pix5[8][2] = 255;
        push5(1'b0, 16);
        send_line5(1'b0, 16);
        idle5();
        drain5();

        // Ramp with replicated borders on the 3x3 instance.
        for (int x = 0; x < 8; x++) for (int r = 0; r < 3; r++) pix3[x][r] = 10 * x;
        push3(1'b0);
        send_line3(1'b0);
        idle3();
        drain3();

        // Rounding: a lone value of 2 lands exactly on the half point.
        for (int x = 0; x < 8; x++) for (int r = 0; r < 3; r++) pix3[x][r] = 0;
        pix3[3][1] = 2;
        push3(1'b0);
        send_line3(1'b0);
        idle3();
        drain3();

        // Same stimulus in bypass.
        b3 = 1'b1;
        push3(1'b1);
        send_line3(1'b0);
        idle3();
        drain3();
        b3 = 1'b0;

        // Three back-to-back random lines with idle gaps.
        for (int l = 0; l < 3; l++) begin
            for (int x = 0; x < 16; x++) for (int r = 0; r < 5; r++) pix5[x][r] = int'($urandom_range(0, 255));
            push5(1'b0, 16);
            send_line5(1'b1, 16);
        end
        idle5();
        drain5();

        for (int l = 0; l < 2; l++) begin
            for (int x = 0; x < 8; x++) for (int r = 0; r < 3; r++) pix3[x][r] = int'($urandom_range(0, 255));
            push3(1'b0);
            send_line3(1'b1);
        end
        idle3();
        drain3();

        // Reset mid-line after columns 0..8; only x=0..6 can have left before it.
        for (int x = 0; x < 16; x++) for (int r = 0; r < 5; r++) pix5[x][r] = int'($urandom_range(0, 255));
        push5(1'b0, 7);
        send_line5(1'b0, 9);
        idle5();
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("midreset_outputs_seen", q5.size(), 0);
        check("midreset_valid_low", int'(ov5), 0);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("midreset_ready", int'(r5), 1);

        // Clean saturated line after reset.
        for (int x = 0; x < 16; x++) for (int r = 0; r < 5; r++) pix5[x][r] = 255;
        push5(1'b0, 16);
        send_line5(1'b0, 16);
        idle5();
        drain5();

        // One more random line to confirm the window was fully reloaded.
        for (int x = 0; x < 16; x++) for (int r = 0; r < 5; r++) pix5[x][r] = int'($urandom_range(0, 255));
        push5(1'b0, 16);
        send_line5(1'b0, 16);
        idle5();
        drain5();

        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
